ram_port_arbiter: RTL and testbench
===================================

Name: ram_port_arbiter

Overview:
- Shares the single RAM port among NREQ cache requesters (icache and dcache of every core) using round-robin arbitration.
- Holds each grant until the RAM reports ACCESS, then moves the pointer on. Gives up a grant on requester withdrawal or on timeout.
- Sits between the coherence/memory controller's cache-side requests and the RAM interface (ramstate_t from cpu_types_pkg).

Parameters:
- CPUS, 2, number of cores; NREQ = 2*CPUS requesters. Index 2k = icache of core k, index 2k+1 = dcache of core k.
- TIMEOUT, 64, maximum cycles in HOLD without ACCESS before the grant is abandoned (must be >= 2).
- IDW, $clog2(2*CPUS), width of the grant index.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- req_ren  in  NREQ  per-requester read request.
- req_wen  in  NREQ  per-requester write request.
- req_addr  in  NREQ*32  flattened word_t addresses; requester i occupies bits [32i+31:32i].
- req_store  in  NREQ*32  flattened write data.
- req_wait  out  NREQ  per-requester wait; low for exactly the completing cycle.
- req_load  out  32  ramload broadcast; valid only for the requester whose req_wait is low.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  ramstate_t  FREE/BUSY/ACCESS/ERROR.
- gnt_valid  out  1  a grant is held (state HOLD).
- gnt_id  out  IDW  index of the granted requester.
- timeout_err  out  1  one-cycle pulse when a grant is abandoned on timeout.

Behaviour:
- Reset values:
  - state=IDLE, ptr=NREQ-1, gnt_id=0, cnt=0.
  - All req_wait=1; ramREN=ramWEN=0; ramaddr=ramstore=0; gnt_valid=0; timeout_err=0.
- A requester is active when req_ren[i] | req_wen[i]. If both are set, WEN wins: ramWEN=1, ramREN=0.
- State IDLE:
  - RAM outputs are 0 and all req_wait are 1.
  - If any requester is active, gnt_id <= first active index searching ptr+1, ptr+2, ... modulo NREQ (wraps past NREQ-1 to 0). Next state is HOLD and cnt <= 0.
  - Otherwise the block stays in IDLE.
- State HOLD:
  - ramREN/ramWEN/ramaddr/ramstore are driven combinationally from requester gnt_id. gnt_valid=1.
  - ramstate==ACCESS: req_wait[gnt_id]=0 in the same cycle and req_load=ramload. Next state IDLE, ptr <= gnt_id.
  - ramstate FREE/BUSY/ERROR: cnt increments and req_wait stays 1.
  - Granted requester goes inactive before ACCESS: next state IDLE with no RAM access asserted that cycle. ptr is unchanged and no wait is dropped.
  - cnt==TIMEOUT-1 without ACCESS: timeout_err=1 for one cycle, next state IDLE, ptr <= gnt_id (the faulty requester loses priority).
  - ACCESS takes precedence over timeout in the same cycle.
- Latency: a request seen in IDLE at cycle n drives RAM at cycle n+1. Minimum completion is n+1 (ACCESS on the first HOLD cycle). Back-to-back grants leave one IDLE bubble between them.
- Fairness: with all NREQ requesters active continuously, each is granted exactly once per NREQ grants.
- Requests arriving during HOLD wait and are considered at the next IDLE.
- Asynchronous reset mid-HOLD immediately forces all reset values; the in-flight access is dropped.
- req_load is 0 whenever no req_wait is low.

Optional Feature:
- Macro: RAM_ARB_DPRIO_EN.
- Defined: in IDLE, if any odd-index (dcache) requester is active, the search covers only dcache requesters, round-robin from ptr+1. icache requesters are granted only when no dcache requester is active. All other behaviour is unchanged.
- Not defined: plain round-robin over all NREQ requesters as above.

Test Plan:
- Reset release, no requests -> all req_wait=1, ramREN=ramWEN=0, gnt_valid=0, stays in IDLE for 20 cycles.
- req_ren[1]=1, addr 0x0000_0040; ramstate BUSY for 3 cycles then ACCESS with ramload=0xDEADBEEF -> ramREN=1, ramaddr=0x40 from cycle n+1; req_wait[1]=0 and req_load=0xDEADBEEF on the ACCESS cycle only; gnt_id=1.
- All 4 requesters (CPUS=2) active continuously, ACCESS every 2nd HOLD cycle -> grant order 0,1,2,3,0,1,... with one IDLE cycle between grants.
- req_wen[3]=1 and req_ren[3]=1 with store 0x12345678 -> ramWEN=1, ramREN=0, ramstore=0x12345678.
- TIMEOUT=8, ramstate held BUSY -> timeout_err high on the 8th HOLD cycle; next grant goes to another active requester; ptr=abandoned id.
- With RAM_ARB_DPRIO_EN defined, req_ren[0] and req_ren[3] both active -> requester 3 granted first, requester 0 granted after 3 completes. Without the macro -> requester 0 granted first from reset.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU/RAM types used by the RAM port arbiter
package cpu_types_pkg;
    typedef logic [31:0] word_t;
    typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
endpackage

// File: rtl/ram_port_arbiter_if.sv
// rtl/ram_port_arbiter_if.sv - requester and RAM side bus of the RAM port arbiter
interface ram_port_arbiter_if #(
    parameter int NREQ = 4
);
    import cpu_types_pkg::*;

    logic [NREQ-1:0]    req_ren;
    logic [NREQ-1:0]    req_wen;
    logic [NREQ*32-1:0] req_addr;
    logic [NREQ*32-1:0] req_store;
    logic [NREQ-1:0]    req_wait;
    word_t              req_load;
    logic               ramREN;
    logic               ramWEN;
    word_t              ramaddr;
    word_t              ramstore;
    word_t              ramload;
    ramstate_t          ramstate;

    modport master (
        output req_ren, req_wen, req_addr, req_store, ramload, ramstate,
        input  req_wait, req_load, ramREN, ramWEN, ramaddr, ramstore
    );

    modport slave (
        input  req_ren, req_wen, req_addr, req_store, ramload, ramstate,
        output req_wait, req_load, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - round-robin arbiter sharing one RAM port among 2*CPUS caches
// Optional macro RAM_ARB_DPRIO_EN: dcache (odd index) requesters win over icache requesters.
module ram_port_arbiter
    import cpu_types_pkg::*;
#(
    parameter int CPUS    = 2,
    parameter int TIMEOUT = 64,
    parameter int IDW     = $clog2(2*CPUS)
) (
    input  logic              CLK,
    input  logic              nRST,
    ram_port_arbiter_if.slave bus,
    output logic              gnt_valid,
    output logic [IDW-1:0]    gnt_id,
    output logic              timeout_err
);
    localparam int NREQ = 2*CPUS;
    localparam int CW   = $clog2(TIMEOUT);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t          state, state_nx;
    logic [IDW-1:0]  ptr, ptr_nx, gnt_nx, pick;
    logic [CW-1:0]   cnt, cnt_nx;
    logic [IDW:0]    slot;
    logic [NREQ-1:0] active, eligible;
    logic            found, gnt_act;
    word_t           addr_a  [NREQ];
    word_t           store_a [NREQ];

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            addr_a[i]  = bus.req_addr[32*i +: 32];
            store_a[i] = bus.req_store[32*i +: 32];
        end
    end

    assign active  = bus.req_ren | bus.req_wen;
    assign gnt_act = active[gnt_id];

`ifdef RAM_ARB_DPRIO_EN
    localparam logic [NREQ-1:0] DMASK = {CPUS{2'b10}};
    assign eligible = (|(active & DMASK)) ? (active & DMASK) : active;
`else
    assign eligible = active;
`endif

    // First eligible requester after ptr, wrapping modulo NREQ.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        slot  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            slot = {1'b0, ptr} + (IDW+1)'(k);
            if (slot >= (IDW+1)'(NREQ))
                slot = slot - (IDW+1)'(NREQ);
            if (!found && eligible[slot[IDW-1:0]]) begin
                found = 1'b1;
                pick  = slot[IDW-1:0];
            end
        end
    end

    assign gnt_valid = (state == HOLD);

    always_comb begin
        bus.req_wait = '1;
        bus.req_load = '0;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        timeout_err  = 1'b0;
        state_nx     = state;
        ptr_nx       = ptr;
        gnt_nx       = gnt_id;
        cnt_nx       = cnt;
        case (state)
            IDLE: begin
                if (found) begin
                    gnt_nx   = pick;
                    cnt_nx   = '0;
                    state_nx = HOLD;
                end
            end
            HOLD: begin
                // A withdrawn requester releases the port silently, ptr untouched.
                if (!gnt_act) begin
                    state_nx = IDLE;
                end else begin
                    bus.ramWEN   = bus.req_wen[gnt_id];
                    bus.ramREN   = bus.req_ren[gnt_id] & ~bus.req_wen[gnt_id];
                    bus.ramaddr  = addr_a[gnt_id];
                    bus.ramstore = store_a[gnt_id];
                    if (bus.ramstate == ACCESS) begin
                        bus.req_wait[gnt_id] = 1'b0;
                        bus.req_load         = bus.ramload;
                        ptr_nx               = gnt_id;
                        state_nx             = IDLE;
                    end else if (cnt == CW'(TIMEOUT-1)) begin
                        timeout_err = 1'b1;
                        ptr_nx      = gnt_id;
                        state_nx    = IDLE;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state  <= IDLE;
            ptr    <= IDW'(NREQ-1);
            gnt_id <= '0;
            cnt    <= '0;
        end else begin
            state  <= state_nx;
            ptr    <= ptr_nx;
            gnt_id <= gnt_nx;
            cnt    <= cnt_nx;
        end
    end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - self-checking bench for ram_port_arbiter (CPUS=2, TIMEOUT=8)
module tb_ram_port_arbiter;
    import cpu_types_pkg::*;

    localparam int CPUS    = 2;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 8;
    localparam int IDW     = 2;

    logic           CLK = 1'b0;
    logic           nRST;
    logic           gnt_valid;
    logic [IDW-1:0] gnt_id;
    logic           timeout_err;

    ram_port_arbiter_if #(.NREQ(NREQ)) bus ();

    ram_port_arbiter #(.CPUS(CPUS), .TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .nRST(nRST), .bus(bus),
        .gnt_valid(gnt_valid), .gnt_id(gnt_id), .timeout_err(timeout_err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0]  rwait;
        logic [31:0] load;
        logic [31:0] addr;
        logic [31:0] store;
        logic        ren;
        logic        wen;
        logic        gv;
        logic [1:0]  gid;
        logic        tmo;
    } out_t;

    typedef struct {
        logic [3:0] ren;
        logic [3:0] wen;
        ramstate_t  rs;
        logic [31:0] rload;
        out_t       exp;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // Reference model: whether a grant is held, by whom, for how many unanswered cycles.
    bit m_hold;
    int m_gid, m_ptr, m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_out(input out_t e);
        chk("req_wait", 32'(bus.req_wait), 32'(e.rwait));
        chk("req_load", bus.req_load, e.load);
        chk("ramREN", 32'(bus.ramREN), 32'(e.ren));
        chk("ramWEN", 32'(bus.ramWEN), 32'(e.wen));
        chk("ramaddr", bus.ramaddr, e.addr);
        chk("ramstore", bus.ramstore, e.store);
        chk("gnt_valid", 32'(gnt_valid), 32'(e.gv));
        chk("gnt_id", 32'(gnt_id), 32'(e.gid));
        chk("timeout_err", 32'(timeout_err), 32'(e.tmo));
    endtask

    function automatic out_t o_idle(input logic [1:0] gid);
        out_t e;
        e.rwait = 4'b1111; e.load = 0; e.addr = 0; e.store = 0;
        e.ren = 0; e.wen = 0; e.gv = 0; e.gid = gid; e.tmo = 0;
        return e;
    endfunction

    function automatic out_t o_hold(input logic [1:0] gid, input logic ren, input logic wen,
                                    input logic [31:0] addr, input logic [31:0] store,
                                    input logic [3:0] rwait, input logic [31:0] load);
        out_t e;
        e.rwait = rwait; e.load = load; e.addr = addr; e.store = store;
        e.ren = ren; e.wen = wen; e.gv = 1; e.gid = gid; e.tmo = 0;
        return e;
    endfunction

    function automatic vec_t mk(input logic [3:0] ren, input logic [3:0] wen, input ramstate_t rs,
                                input logic [31:0] rload, input out_t e);
        vec_t v;
        v.ren = ren; v.wen = wen; v.rs = rs; v.rload = rload; v.exp = e;
        return v;
    endfunction

    // Closest active (or, with dcache priority, closest active dcache) requester after m_ptr.
    function automatic int m_pick(input logic [NREQ-1:0] act);
        logic [NREQ-1:0] el;
        int best, bestd, d;
        el = act;
`ifdef RAM_ARB_DPRIO_EN
        if ((act & 4'b1010) != 0) el = act & 4'b1010;
`endif
        best = -1;
        bestd = NREQ;
        for (int i = 0; i < NREQ; i++) begin
            d = (i - m_ptr - 1 + 2*NREQ) % NREQ;
            if (el[i] && d < bestd) begin
                best = i;
                bestd = d;
            end
        end
        return best;
    endfunction

    function automatic out_t m_expect();
        out_t e;
        logic [NREQ-1:0] act;
        int g;
        act = bus.req_ren | bus.req_wen;
        e = o_idle(m_gid[1:0]);
        e.gv = m_hold;
        g = m_gid;
        if (m_hold && act[g]) begin
            e.wen = bus.req_wen[g];
            e.ren = bus.req_ren[g] & ~bus.req_wen[g];
            e.addr = bus.req_addr[32*g +: 32];
            e.store = bus.req_store[32*g +: 32];
            if (bus.ramstate == ACCESS) begin
                e.rwait[g] = 1'b0;
                e.load = bus.ramload;
            end else if (m_cnt == TIMEOUT-1) begin
                e.tmo = 1'b1;
            end
        end
        return e;
    endfunction

    task automatic m_reset();
        m_hold = 0; m_gid = 0; m_ptr = NREQ-1; m_cnt = 0;
    endtask

    task automatic m_update();
        logic [NREQ-1:0] act;
        int p;
        act = bus.req_ren | bus.req_wen;
        if (!m_hold) begin
            p = m_pick(act);
            if (p >= 0) begin
                m_hold = 1; m_gid = p; m_cnt = 0;
            end
        end else if (!act[m_gid]) begin
            m_hold = 0;
        end else if (bus.ramstate == ACCESS || m_cnt == TIMEOUT-1) begin
            m_hold = 0; m_ptr = m_gid;
        end else begin
            m_cnt++;
        end
    endtask

    // Inputs are set just after a falling edge; outputs are checked 1ns later.
    task automatic mstep();
        #1;
        check_out(m_expect());
        @(posedge CLK);
        m_update();
        @(negedge CLK);
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        m_reset();
        @(negedge CLK);
        #1;
        check_out(o_idle(2'd0));
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    task automatic set_inputs(input logic [3:0] ren, input logic [3:0] wen, input ramstate_t rs,
                              input logic [31:0] rload);
        bus.req_ren = ren; bus.req_wen = wen; bus.ramstate = rs; bus.ramload = rload;
    endtask

    vec_t tbl [18];
    int   fair_order [4];

    initial begin
        nRST = 1'b0;
        set_inputs(4'b0, 4'b0, FREE, 32'h0);
        for (int i = 0; i < NREQ; i++) begin
            bus.req_addr[32*i +: 32]  = 32'h40 * i;
            bus.req_store[32*i +: 32] = (i == 3) ? 32'h1234_5678 : 32'hA0 + i;
        end
        do_reset();

        // Idle after reset with no requests.
        for (int c = 0; c < 20; c++) begin
            #1;
            check_out(o_idle(2'd0));
            @(posedge CLK); m_update(); @(negedge CLK);
        end

        tbl[0]  = mk(4'b0010, 4'b0000, FREE,   32'h0, o_idle(2'd0));
        tbl[1]  = mk(4'b0010, 4'b0000, BUSY,   32'h0, o_hold(2'd1, 1, 0, 32'h40, 32'hA1, 4'b1111, 32'h0));
        tbl[2]  = tbl[1];
        tbl[3]  = tbl[1];
        tbl[4]  = mk(4'b0010, 4'b0000, ACCESS, 32'hDEADBEEF,
                     o_hold(2'd1, 1, 0, 32'h40, 32'hA1, 4'b1101, 32'hDEADBEEF));
        tbl[5]  = mk(4'b0010, 4'b0000, FREE,   32'hDEADBEEF, o_idle(2'd1));
        tbl[6]  = mk(4'b0000, 4'b0000, FREE,   32'h0, o_hold(2'd1, 0, 0, 32'h0, 32'h0, 4'b1111, 32'h0));
        tbl[7]  = mk(4'b0000, 4'b0000, FREE,   32'h0, o_idle(2'd1));
        tbl[8]  = mk(4'b1000, 4'b1000, FREE,   32'h0, o_idle(2'd1));
        tbl[9]  = mk(4'b1000, 4'b1000, BUSY,   32'h0,
                     o_hold(2'd3, 0, 1, 32'hC0, 32'h1234_5678, 4'b1111, 32'h0));
        tbl[10] = mk(4'b1000, 4'b1000, ACCESS, 32'h55,
                     o_hold(2'd3, 0, 1, 32'hC0, 32'h1234_5678, 4'b0111, 32'h55));
        tbl[11] = mk(4'b0000, 4'b0000, FREE,   32'h0, o_idle(2'd3));
        tbl[12] = mk(4'b1001, 4'b0000, FREE,   32'h0, o_idle(2'd3));
`ifdef RAM_ARB_DPRIO_EN
        tbl[13] = mk(4'b1001, 4'b0000, ACCESS, 32'h77,
                     o_hold(2'd3, 1, 0, 32'hC0, 32'h1234_5678, 4'b0111, 32'h77));
        tbl[14] = mk(4'b0001, 4'b0000, FREE,   32'h0, o_idle(2'd3));
        tbl[15] = mk(4'b0001, 4'b0000, BUSY,   32'h0, o_hold(2'd0, 1, 0, 32'h0, 32'hA0, 4'b1111, 32'h0));
        tbl[16] = mk(4'b0001, 4'b0000, ACCESS, 32'h99, o_hold(2'd0, 1, 0, 32'h0, 32'hA0, 4'b1110, 32'h99));
        tbl[17] = mk(4'b0000, 4'b0000, FREE,   32'h0, o_idle(2'd0));
        fair_order = '{1, 3, 1, 3};
`else
        tbl[13] = mk(4'b1001, 4'b0000, ACCESS, 32'h77, o_hold(2'd0, 1, 0, 32'h0, 32'hA0, 4'b1110, 32'h77));
        tbl[14] = mk(4'b1000, 4'b0000, FREE,   32'h0, o_idle(2'd0));
        tbl[15] = mk(4'b1000, 4'b0000, BUSY,   32'h0,
                     o_hold(2'd3, 1, 0, 32'hC0, 32'h1234_5678, 4'b1111, 32'h0));
        tbl[16] = mk(4'b1000, 4'b0000, ACCESS, 32'h99,
                     o_hold(2'd3, 1, 0, 32'hC0, 32'h1234_5678, 4'b0111, 32'h99));
        tbl[17] = mk(4'b0000, 4'b0000, FREE,   32'h0, o_idle(2'd3));
        fair_order = '{0, 1, 2, 3};
`endif
        for (int r = 0; r < 18; r++) begin
            set_inputs(tbl[r].ren, tbl[r].wen, tbl[r].rs, tbl[r].rload);
            #1;
            check_out(tbl[r].exp);
            @(posedge CLK); m_update(); @(negedge CLK);
        end

        // Fairness: everyone requesting, ACCESS on every second HOLD cycle.
        do_reset();
        for (int c = 0; c < 24; c++) begin
            set_inputs(4'b1111, 4'b0000, (c % 3 == 1) ? BUSY : (c % 3 == 2) ? ACCESS : FREE, 32'(c));
            if (c % 3 == 1) begin
                #1;
                chk("fair_gnt_id", 32'(gnt_id), 32'(fair_order[(c/3) % 4]));
                chk("fair_gnt_valid", 32'(gnt_valid), 32'd1);
                #(-0);
            end
            mstep();
            if (c % 3 == 1) #0;
        end

        // Timeout: requester 1 never answered, requester 3 takes over.
        do_reset();
        for (int c = 0; c < 12; c++) begin
            set_inputs(4'b1010, 4'b0000, BUSY, 32'h0);
            #1;
            if (c == 8)  chk("tmo_pulse", 32'(timeout_err), 32'd1);
            if (c == 7)  chk("tmo_early", 32'(timeout_err), 32'd0);
            if (c == 10) chk("tmo_next_gnt", 32'(gnt_id), 32'd3);
            check_out(m_expect());
            @(posedge CLK); m_update(); @(negedge CLK);
        end

        // Asynchronous reset while a grant is held.
        set_inputs(4'b0100, 4'b0000, BUSY, 32'h0);
        mstep();
        mstep();
        #2;
        chk("pre_rst_gnt_valid", 32'(gnt_valid), 32'd1);
        nRST = 1'b0;
        m_reset();
        #1;
        check_out(o_idle(2'd0));
        @(negedge CLK);
        nRST = 1'b1;
        set_inputs(4'b0000, 4'b0000, FREE, 32'h0);
        mstep();

        // Randomised traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            int r;
            for (int i = 0; i < NREQ; i++) begin
                if ($urandom_range(7) == 0)  bus.req_ren[i] = ~bus.req_ren[i];
                if ($urandom_range(15) == 0) bus.req_wen[i] = ~bus.req_wen[i];
                bus.req_addr[32*i +: 32]  = $urandom;
                bus.req_store[32*i +: 32] = $urandom;
            end
            r = $urandom_range(7);
            bus.ramstate = (r < 2) ? ACCESS : (r == 2) ? ERROR : (r == 3) ? FREE : BUSY;
            bus.ramload  = $urandom;
            mstep();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
